// File: rtl/top_hash.sv
// top_hash: XOR-fold of a MSG_WIDTH message into a HASH_WIDTH digest, registered once.
// Optional build macro HASH_ROTATE_EN rotates word i left by 8*i before the fold.
`default_nettype none

module top_hash #(
  parameter int MSG_WIDTH  = 128,
  parameter int HASH_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MSG_WIDTH-1:0]  message,
  output logic [HASH_WIDTH-1:0] hash_result
);

  localparam int c_N_WORDS = MSG_WIDTH / HASH_WIDTH;

  generate
    if ((MSG_WIDTH % HASH_WIDTH) != 0) begin : g_width_check
      $error("top_hash: MSG_WIDTH must be a multiple of HASH_WIDTH");
    end
  endgenerate

  logic [HASH_WIDTH-1:0] w_words [c_N_WORDS];
  logic [HASH_WIDTH-1:0] w_digest;
  logic [HASH_WIDTH-1:0] r_hash;

  // Word 0 is the most significant slice of the message.
  generate
    for (genvar gi = 0; gi < c_N_WORDS; gi++) begin : g_word
      logic [HASH_WIDTH-1:0] w_raw;
      assign w_raw = message[MSG_WIDTH-1-gi*HASH_WIDTH -: HASH_WIDTH];
`ifdef HASH_ROTATE_EN
      localparam int c_ROT = (8 * gi) % HASH_WIDTH;
      logic [2*HASH_WIDTH-1:0] w_dbl;
      assign w_dbl       = {w_raw, w_raw};
      assign w_words[gi] = w_dbl[2*HASH_WIDTH-1-c_ROT -: HASH_WIDTH];
`else
      assign w_words[gi] = w_raw;
`endif
    end
  endgenerate

  always_comb begin
    w_digest = '0;
    for (int i = 0; i < c_N_WORDS; i++) begin
      w_digest = w_digest ^ w_words[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hash <= '0;
    end else begin
      r_hash <= w_digest;
    end
  end

  assign hash_result = r_hash;

endmodule

`default_nettype wire

// File: tb/tb_top_hash.sv
// Scoreboard bench for top_hash: stimulus pushes expected digests, monitor pops one per clock.
`default_nettype none

module tb_top_hash;

  logic         clk;
  logic         reset;
  logic [127:0] message;
  logic [31:0]  hash_result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];

  top_hash #(.MSG_WIDTH(128), .HASH_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .message     (message),
    .hash_result (hash_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] c_MSG_A = 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0;
`ifdef HASH_ROTATE_EN
  localparam logic [31:0] c_EXP_A  = 32'h86F5AECF;
  localparam logic [31:0] c_EXP_W1 = 32'h0000AB00;
  localparam logic [31:0] c_EXP_W2 = 32'hFFFF0000;
  localparam logic [31:0] c_EXP_W3 = 32'h78123456;
`else
  localparam logic [31:0] c_EXP_A  = 32'h9CDB8CD9;
  localparam logic [31:0] c_EXP_W1 = 32'h000000AB;
  localparam logic [31:0] c_EXP_W2 = 32'h0000FFFF;
  localparam logic [31:0] c_EXP_W3 = 32'h12345678;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge; the digest is due after the next rising edge.
  task automatic drive(input logic [127:0] msg, input logic [31:0] exp, input string name);
    @(negedge clk);
    message = msg;
    sb_q.push_back('{exp: exp, name: name});
  endtask

  // Monitor: the output register presents a new value every rising edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, hash_result, e.exp);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    message = c_MSG_A;
    #1;
    check("reset_immediate", hash_result, 32'h0);
    repeat (3) drive(c_MSG_A, 32'h0, "reset_held");

    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back('{exp: c_EXP_A, name: "first_capture"});

    drive(128'h0, 32'h0, "all_zero");
    drive({128{1'b1}}, 32'h0, "all_ones");
    drive(128'h00000001_00000000_00000000_00000000, 32'h1, "single_bit_w0");

    // Back-to-back changes: each digest must land exactly one clock later.
    drive(128'h11111111_00000000_00000000_00000000, 32'h11111111, "seq0");
    drive(128'h00000000_000000AB_00000000_00000000, c_EXP_W1,     "seq1_w1");
    drive(128'h00000000_00000000_0000FFFF_00000000, c_EXP_W2,     "seq2_w2");
    drive(128'h00000000_00000000_00000000_12345678, c_EXP_W3,     "seq3_w3");
    drive(128'h22222222_00000000_00000000_00000000, 32'h22222222, "seq4");
    drive(128'h22222222_00000000_00000000_00000000, 32'h22222222, "seq5_repeat");
    drive(c_MSG_A, c_EXP_A, "msg_a_again");

    // Async reset between edges while the output is non-zero.
    @(posedge clk);
    #3;
    check("pre_reset_nonzero", hash_result, c_EXP_A);
    reset = 1'b0;
    #1;
    check("async_clear", hash_result, 32'h0);
    @(posedge clk);
    #1;
    check("held_in_reset", hash_result, 32'h0);
    @(negedge clk);
    message = 128'h00000000_00000000_00000000_12345678;
    reset   = 1'b1;
    sb_q.push_back('{exp: c_EXP_W3, name: "post_reset_capture"});

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
